// File: rtl/arb_req_gather_if.sv
// Bundle of client push, arbiter and output handshake signals for arb_req_gather.
//   in_valid_i/in_data_i/in_ready_o : per-client push (client k at [k*DW +: DW])
//   req_o/grant_i                   : request out to, one-hot grant back from, the arbiter
//   out_valid_o/out_data_o/out_src_o/out_ready_i : gathered output stream
//   err_o                           : sticky illegal-grant flag
// slave = the gather block's view, master = the environment driving it.
interface arb_req_gather_if #(
   parameter int ARB_WIDTH  = 8,
   parameter int DATA_WIDTH = 32
);
   localparam int SW = $clog2(ARB_WIDTH);

   logic [ARB_WIDTH-1:0]            in_valid_i;
   logic [ARB_WIDTH*DATA_WIDTH-1:0] in_data_i;
   logic [ARB_WIDTH-1:0]            in_ready_o;
   logic [ARB_WIDTH-1:0]            req_o;
   logic [ARB_WIDTH-1:0]            grant_i;
   logic                            out_valid_o;
   logic [DATA_WIDTH-1:0]           out_data_o;
   logic [SW-1:0]                   out_src_o;
   logic                            out_ready_i;
   logic                            err_o;

   modport slave (
      input  in_valid_i, in_data_i, grant_i, out_ready_i,
      output in_ready_o, req_o, out_valid_o, out_data_o, out_src_o, err_o
   );

   modport master (
      output in_valid_i, in_data_i, grant_i, out_ready_i,
      input  in_ready_o, req_o, out_valid_o, out_data_o, out_src_o, err_o
   );
endinterface

// File: rtl/arb_req_gather.sv
// arb_req_gather: per-client FIFOs feeding an external round-robin arbiter;
// the granted head is popped into a single registered output stage.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : arb_req_gather_if.slave (push ports, req/grant, output stream, err)
// Parameters: ARB_WIDTH clients (>=2), DATA_WIDTH payload bits, DEPTH entries
// per client FIFO (power of two, >=2).

// One client FIFO. Pointers are $clog2(DEPTH) bits and wrap naturally.
module arb_req_gather_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][DW-1:0] mem_q;
   logic [PW-1:0]            wptr_q, rptr_q;
   logic [CW-1:0]            cnt_q, cnt_d;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign rdata_o = mem_q[rptr_q];

   always_comb begin
      cnt_d = cnt_q;
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage needs no reset: an empty FIFO never presents its contents.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_i) wptr_q <= wptr_q + PW'(1);
         if (pop_i)  rptr_q <= rptr_q + PW'(1);
         cnt_q <= cnt_d;
      end
   end
endmodule

module arb_req_gather #(
   parameter int ARB_WIDTH  = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   arb_req_gather_if.slave   bus
);
   localparam int N  = ARB_WIDTH;
   localparam int DW = DATA_WIDTH;
   localparam int SW = $clog2(N);

   logic [N-1:0][DW-1:0] head;
   logic [N-1:0]         full, empty, push, pop;
   logic                 free, onehot, legal, illegal;
   logic [SW-1:0]        sel_idx;
   logic [DW-1:0]        sel_data;

   logic                 out_valid_q, out_valid_d;
   logic [DW-1:0]        out_data_q, out_data_d;
   logic [SW-1:0]        out_src_q, out_src_d;
   logic                 err_q, err_d;

   for (genvar g = 0; g < N; g++) begin : g_fifo
      arb_req_gather_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .push_i  (push[g]),
         .wdata_i (bus.in_data_i[g*DW +: DW]),
         .pop_i   (pop[g]),
         .rdata_o (head[g]),
         .full_o  (full[g]),
         .empty_o (empty[g])
      );
   end

   // Ready is purely "not full": a same-cycle pop does not open a slot.
   assign bus.in_ready_o = ~full;
   assign push           = bus.in_valid_i & ~full;

   assign free      = ~out_valid_q | bus.out_ready_i;
   assign bus.req_o = ~empty & {N{free}};

   // A one-hot grant hitting req_o is necessarily a subset of it.
   assign onehot  = (bus.grant_i != '0) && ((bus.grant_i & (bus.grant_i - N'(1))) == '0);
   assign legal   = onehot && ((bus.grant_i & bus.req_o) != '0);
   assign illegal = (bus.grant_i != '0) && !legal;
   assign pop     = legal ? bus.grant_i : '0;

   always_comb begin
      sel_idx  = '0;
      sel_data = '0;
      for (int k = 0; k < N; k++) begin
         if (bus.grant_i[k]) begin
            sel_idx  = SW'(k);
            sel_data = head[k];
         end
      end
   end

   // A legal grant reloads the output even while a transfer drains it,
   // giving one transfer per cycle.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      err_d       = err_q | illegal;
      if (legal) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_src_d   = sel_idx;
      end else if (free) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         err_q       <= err_d;
      end
   end

   assign bus.out_valid_o = out_valid_q;
   assign bus.out_data_o  = out_data_q;
   assign bus.out_src_o   = out_src_q;
   assign bus.err_o       = err_q;
endmodule

// File: tb/tb_arb_req_gather.sv
// Bench for arb_req_gather at N=4, DW=8, DEPTH=2: a vector table with
// hand-derived expectations plus a payload scoreboard fed by a client-FIFO model.
module tb_arb_req_gather;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   arb_req_gather_if #(.ARB_WIDTH(4), .DATA_WIDTH(8)) bus ();

   arb_req_gather #(.ARB_WIDTH(4), .DATA_WIDTH(8), .DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0]  v;
      logic [31:0] d;
      logic [3:0]  g;
      logic        r;
      logic [3:0]  e_req;
      logic [3:0]  e_rdy;
      logic        e_ov;
      logic [7:0]  e_dat;
      logic [1:0]  e_src;
      logic        e_err;
   } vec_t;

   vec_t tv[36];
   int n_tests = 0;
   int n_fail  = 0;

   // Client-FIFO model and expected-output queue {src, data}.
   int         m_cnt[4];
   logic [7:0] m_buf[4][2];
   logic       m_ov;
   logic [9:0] exp_q[$];

   function automatic vec_t mk(logic [3:0] v, logic [31:0] d, logic [3:0] g, logic r,
                               logic [3:0] e_req, logic [3:0] e_rdy, logic e_ov,
                               logic [7:0] e_dat, logic [1:0] e_src, logic e_err);
      vec_t t;
      t.v = v; t.d = d; t.g = g; t.r = r; t.e_req = e_req; t.e_rdy = e_rdy;
      t.e_ov = e_ov; t.e_dat = e_dat; t.e_src = e_src; t.e_err = e_err;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      m_ov = 1'b0;
      exp_q.delete();
   endtask

   task automatic run_row(input int i);
      vec_t t;
      logic [3:0] mreq, mrdy;
      logic free, legal;
      logic [9:0] e;
      t = tv[i];
      @(negedge clk);
      bus.in_valid_i  = t.v;
      bus.in_data_i   = t.d;
      bus.grant_i     = t.g;
      bus.out_ready_i = t.r;
      #1;
      chk($sformatf("row%0d req", i), 32'(bus.req_o), 32'(t.e_req));
      chk($sformatf("row%0d in_ready", i), 32'(bus.in_ready_o), 32'(t.e_rdy));
      free = !m_ov || t.r;
      for (int k = 0; k < 4; k++) begin
         mreq[k] = (m_cnt[k] != 0) && free;
         mrdy[k] = (m_cnt[k] < 2);
      end
      legal = (t.g != 4'd0) && ((t.g & (t.g - 4'd1)) == 4'd0) && ((t.g & mreq) != 4'd0);
      if (bus.out_valid_o && t.r) begin
         if (exp_q.size() == 0) chk($sformatf("row%0d sb_unexpected", i), 32'd1, 32'd0);
         else begin
            e = exp_q.pop_front();
            chk($sformatf("row%0d sb_payload", i), 32'({bus.out_src_o, bus.out_data_o}), 32'(e));
         end
      end
      @(posedge clk);
      if (legal) begin
         for (int k = 0; k < 4; k++) if (t.g[k]) begin
            exp_q.push_back({2'(k), m_buf[k][0]});
            m_buf[k][0] = m_buf[k][1];
            m_cnt[k]--;
         end
      end
      for (int k = 0; k < 4; k++) if (t.v[k] && mrdy[k]) begin
         m_buf[k][m_cnt[k]] = t.d[k*8 +: 8];
         m_cnt[k]++;
      end
      if (legal) m_ov = 1'b1;
      else if (free) m_ov = 1'b0;
      #1;
      chk($sformatf("row%0d out_valid", i), 32'(bus.out_valid_o), 32'(t.e_ov));
      chk($sformatf("row%0d err", i), 32'(bus.err_o), 32'(t.e_err));
      if (t.e_ov) begin
         chk($sformatf("row%0d out_data", i), 32'(bus.out_data_o), 32'(t.e_dat));
         chk($sformatf("row%0d out_src", i), 32'(bus.out_src_o), 32'(t.e_src));
      end
   endtask

   initial begin
      //             v        d             g        r     req      rdy      ov    dat    src  err
      // single push
      tv[0]  = mk(4'b0001, 32'h0000_00A5, 4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0);
      tv[1]  = mk(4'b0000, 32'h0,         4'b0001, 1'b1, 4'b0001, 4'b1111, 1'b1, 8'hA5, 2'd0, 1'b0);
      tv[2]  = mk(4'b0000, 32'h0,         4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0);
      // backpressure
      tv[3]  = mk(4'b0011, 32'h0000_2211, 4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0);
      tv[4]  = mk(4'b0000, 32'h0,         4'b0001, 1'b0, 4'b0011, 4'b1111, 1'b1, 8'h11, 2'd0, 1'b0);
      tv[5]  = mk(4'b0000, 32'h0,         4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b1, 8'h11, 2'd0, 1'b0);
      tv[6]  = mk(4'b0000, 32'h0,         4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b1, 8'h11, 2'd0, 1'b0);
      tv[7]  = mk(4'b0000, 32'h0,         4'b0010, 1'b1, 4'b0010, 4'b1111, 1'b1, 8'h22, 2'd1, 1'b0);
      tv[8]  = mk(4'b0000, 32'h0,         4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0);
      // full FIFO on client 2, pop while full, push+pop, pointer wrap
      tv[9]  = mk(4'b0100, 32'h0001_0000, 4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0);
      tv[10] = mk(4'b0100, 32'h0002_0000, 4'b0000, 1'b1, 4'b0100, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0);
      tv[11] = mk(4'b0100, 32'h0003_0000, 4'b0000, 1'b1, 4'b0100, 4'b1011, 1'b0, 8'h00, 2'd0, 1'b0);
      tv[12] = mk(4'b0100, 32'h0004_0000, 4'b0100, 1'b1, 4'b0100, 4'b1011, 1'b1, 8'h01, 2'd2, 1'b0);
      tv[13] = mk(4'b0100, 32'h0005_0000, 4'b0100, 1'b1, 4'b0100, 4'b1111, 1'b1, 8'h02, 2'd2, 1'b0);
      tv[14] = mk(4'b0000, 32'h0,         4'b0100, 1'b1, 4'b0100, 4'b1111, 1'b1, 8'h05, 2'd2, 1'b0);
      tv[15] = mk(4'b0000, 32'h0,         4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0);
      // round-robin drain of two entries per client
      tv[16] = mk(4'b1111, 32'h1312_1110, 4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0);
      tv[17] = mk(4'b1111, 32'h2322_2120, 4'b0001, 1'b1, 4'b1111, 4'b1111, 1'b1, 8'h10, 2'd0, 1'b0);
      tv[18] = mk(4'b0000, 32'h0,         4'b0010, 1'b1, 4'b1111, 4'b0001, 1'b1, 8'h11, 2'd1, 1'b0);
      tv[19] = mk(4'b0000, 32'h0,         4'b0100, 1'b1, 4'b1111, 4'b0011, 1'b1, 8'h12, 2'd2, 1'b0);
      tv[20] = mk(4'b0000, 32'h0,         4'b1000, 1'b1, 4'b1111, 4'b0111, 1'b1, 8'h13, 2'd3, 1'b0);
      tv[21] = mk(4'b0000, 32'h0,         4'b0001, 1'b1, 4'b1111, 4'b1111, 1'b1, 8'h20, 2'd0, 1'b0);
      tv[22] = mk(4'b0000, 32'h0,         4'b0010, 1'b1, 4'b1110, 4'b1111, 1'b1, 8'h21, 2'd1, 1'b0);
      tv[23] = mk(4'b0000, 32'h0,         4'b0100, 1'b1, 4'b1100, 4'b1111, 1'b1, 8'h22, 2'd2, 1'b0);
      tv[24] = mk(4'b0000, 32'h0,         4'b1000, 1'b1, 4'b1000, 4'b1111, 1'b1, 8'h23, 2'd3, 1'b0);
      tv[25] = mk(4'b0000, 32'h0,         4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0);
      // illegal grants, sticky err
      tv[26] = mk(4'b0010, 32'h0000_7700, 4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0);
      tv[27] = mk(4'b0000, 32'h0,         4'b0100, 1'b1, 4'b0010, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b1);
      tv[28] = mk(4'b0000, 32'h0,         4'b0011, 1'b1, 4'b0010, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b1);
      tv[29] = mk(4'b0000, 32'h0,         4'b0010, 1'b1, 4'b0010, 4'b1111, 1'b1, 8'h77, 2'd1, 1'b1);
      tv[30] = mk(4'b1000, 32'h9900_0000, 4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b1, 8'h77, 2'd1, 1'b1);
      // after mid-operation reset
      tv[31] = mk(4'b0000, 32'h0,         4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0);
      tv[32] = mk(4'b0000, 32'h0,         4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0);
      tv[33] = mk(4'b1000, 32'h5A00_0000, 4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0);
      tv[34] = mk(4'b0000, 32'h0,         4'b1000, 1'b1, 4'b1000, 4'b1111, 1'b1, 8'h5A, 2'd3, 1'b0);
      tv[35] = mk(4'b0000, 32'h0,         4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0);

      rst_n           = 1'b0;
      bus.in_valid_i  = '0;
      bus.in_data_i   = '0;
      bus.grant_i     = '0;
      bus.out_ready_i = 1'b0;
      model_reset();
      #2;
      chk("reset out_valid", 32'(bus.out_valid_o), 32'd0);
      chk("reset err", 32'(bus.err_o), 32'd0);
      chk("reset req", 32'(bus.req_o), 32'd0);
      chk("reset in_ready", 32'(bus.in_ready_o), 32'hF);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i <= 30; i++) run_row(i);

      // Reset while out_valid_o=1, client 3 holding data and 0x77 still on the output.
      chk("pre-reset sb depth", 32'(exp_q.size()), 32'd1);
      @(negedge clk);
      rst_n           = 1'b0;
      bus.in_valid_i  = '0;
      bus.grant_i     = '0;
      bus.out_ready_i = 1'b1;
      #1;
      chk("midrst out_valid", 32'(bus.out_valid_o), 32'd0);
      chk("midrst out_data", 32'(bus.out_data_o), 32'd0);
      chk("midrst out_src", 32'(bus.out_src_o), 32'd0);
      chk("midrst err", 32'(bus.err_o), 32'd0);
      chk("midrst req", 32'(bus.req_o), 32'd0);
      chk("midrst in_ready", 32'(bus.in_ready_o), 32'hF);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      for (int i = 31; i <= 35; i++) run_row(i);
      chk("final sb empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
